dmem_access_ctrl: RTL



---
 rtl/dmem_access_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer; optional watchdog via DMEM_TIMEOUT_EN
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        hold,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [31:0] r_load_data;

    logic [1:0]  w_off;
    logic        w_legal;
    logic        w_aligned;
    logic [3:0]  w_mask;
    logic        w_issue;
    logic        w_reject;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_fmt;

    // Decode the incoming request: legality, alignment and byte-lane mask
    always_comb begin
        w_off = req_addr[1:0];
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_store;
            default:                w_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   w_aligned = !w_off[0];
            2'b10:   w_aligned = (w_off == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b00:   w_mask = 4'b0001 << w_off;
            2'b01:   w_mask = 4'b0011 << w_off;
            default: w_mask = 4'b1111;
        endcase
        // Reset masks everything so a request held across reset never reaches memory
        w_issue  = !rst && (r_state == S_IDLE) && req_valid && w_legal && w_aligned;
        w_reject = !rst && (r_state == S_IDLE) && req_valid && !(w_legal && w_aligned);
    end

    // Align and extend read data using the offset/width captured at issue
    always_comb begin
        w_shifted = dmem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_fmt = {24'h000000, w_shifted[7:0]};
            3'b001:  w_fmt = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_fmt = {16'h0000, w_shifted[15:0]};
            3'b010:  w_fmt = w_shifted;
            default: w_fmt = 32'h0;
        endcase
        if (r_store) begin
            w_fmt = 32'h0;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_timeout_err;

    // Count WAIT cycles from zero on each issue; the error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT && !dmem_resp) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // The last permitted WAIT cycle without a response gives up; a response in that cycle still wins
    assign w_timeout   = !rst && (r_state == S_WAIT) && !dmem_resp
                         && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and output decode; every output idles at zero
    always_comb begin
        w_state_nxt = r_state;
        dmem_addr   = 32'h0;
        dmem_rmask  = 4'h0;
        dmem_wmask  = 4'h0;
        dmem_wdata  = 32'h0;
        stall       = 1'b0;
        done        = 1'b0;
        load_data   = 32'h0;
        misaligned  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        dmem_addr = {req_addr[31:2], 2'b00};
                        if (req_store) begin
                            dmem_wmask = w_mask;
                            dmem_wdata = req_wdata << {w_off, 3'b000};
                        end else begin
                            dmem_rmask = w_mask;
                        end
                        stall       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else if (w_reject) begin
                        misaligned = 1'b1;
                        done       = 1'b1;
                    end
                end
                S_WAIT: begin
                    dmem_addr = r_addr;
                    if (dmem_resp) begin
                        done        = 1'b1;
                        load_data   = w_fmt;
                        w_state_nxt = hold ? S_DONE : S_IDLE;
                    end else if (w_timeout) begin
                        done        = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_DONE: begin
                    // Parked until the pipeline moves so the held instruction is not issued twice
                    load_data = r_load_data;
                    if (!hold) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register plus the request fields captured at issue and the finished load result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'h0;
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_store     <= 1'b0;
            r_load_data <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr   <= {req_addr[31:2], 2'b00};
                r_off    <= w_off;
                r_funct3 <= req_funct3;
                r_store  <= req_store;
            end
            if (r_state == S_WAIT && dmem_resp) begin
                r_load_data <= w_fmt;
            end
        end
    end

endmodule
